// File: rtl/apb_timer32_pkg.sv
// Register map, control/status bit positions and the CTRL register layout for apb_timer32.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package apb_timer32_pkg;

  // Byte addresses, fully decoded on 20 bits
  localparam logic [19:0] TMR_CTRL  = 20'h00000;
  localparam logic [19:0] TMR_PRESC = 20'h00004;
  localparam logic [19:0] TMR_CMP0  = 20'h00008;
  localparam logic [19:0] TMR_CMP1  = 20'h00009;
  localparam logic [19:0] TMR_CMP2  = 20'h0000A;
  localparam logic [19:0] TMR_CMP3  = 20'h0000B;
  localparam logic [19:0] TMR_CNT0  = 20'h0000C;
  localparam logic [19:0] TMR_CNT1  = 20'h0000D;
  localparam logic [19:0] TMR_CNT2  = 20'h0000E;
  localparam logic [19:0] TMR_CNT3  = 20'h0000F;
  localparam logic [19:0] TMR_STAT  = 20'h00010;

  // CTRL bit indices
  localparam int CTRL_EN       = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_PWM_EN   = 3;

  // STAT bit indices
  localparam int STAT_MATCH = 0;
  localparam int STAT_RUN   = 1;

  // CTRL register, MSB first so that {4'b0, ctrl} is the read-back byte
  typedef struct packed {
    logic pwm_en;
    logic irq_en;
    logic periodic;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/tmr_prescaler.sv
// Prescaler: counts 0..presc while enabled and pulses tick on the terminal count.
// Latency: tick is combinational from the counter flop; the counter restarts the cycle after a tick.
// Backpressure: none; en=0 freezes the count, clr forces it back to zero.
module tmr_prescaler #(
  parameter int PRE_W = 8
) (
  input  logic             apb_pclk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [PRE_W-1:0] presc,
  output logic             tick
);

  logic [PRE_W-1:0] pre_cnt;

  assign tick = en & (pre_cnt == presc);

  // Divider state: cleared on reset or restart, wraps to zero after each tick
  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      pre_cnt <= '0;
    end else if (clr) begin
      pre_cnt <= '0;
    end else if (en) begin
      pre_cnt <= tick ? '0 : pre_cnt + PRE_W'(1);
    end
  end

endmodule

// File: rtl/apb_timer32.sv
// 32-bit APB timer: prescaled counter, compare match, W1C match flag, level IRQ; optional PWM under `TIMER_PWM_EN.
// Latency: single-cycle APB access; MATCH/timer_int visible the cycle after the matching tick; pwm_o lags one cycle.
// Backpressure: none; every access completes in its enable cycle and reads are combinational from apb_paddr.
module apb_timer32
  import apb_timer32_pkg::*;
#(
  parameter int CNT_W = 32,
  parameter int PRE_W = 8
) (
  input  logic        apb_pclk,
  input  logic        rst,
  input  logic        apb_psel,
  input  logic        apb_penable,
  input  logic        apb_pwrite,
  input  logic [19:0] apb_paddr,
  input  logic [7:0]  apb_pwdata,
  output logic [7:0]  apb_prdata,
  output logic        timer_int,
  output logic        pwm_o
);

  logic             we;
  logic             re;
  logic             ctrl_sel;
  logic             presc_sel;
  logic             cmp_sel;
  logic             cnt_sel;
  logic             stat_sel;
  logic [1:0]       lane;

  ctrl_t            ctrl;
  logic [PRE_W-1:0] presc;
  logic [CNT_W-1:0] cmp;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-9:0] snap;
  logic             match;

  logic             tick;
  logic             cnt_wr;
  logic             cnt_hit;
  logic             match_set;
  logic             pre_clr;

  assign we = apb_psel & apb_penable & apb_pwrite;
  assign re = apb_psel & apb_penable & ~apb_pwrite;

  // CMP and CNT are each one aligned 4-byte window; lane picks the byte, LSB first
  assign ctrl_sel  = (apb_paddr == TMR_CTRL);
  assign presc_sel = (apb_paddr == TMR_PRESC);
  assign cmp_sel   = (apb_paddr[19:2] == TMR_CMP0[19:2]);
  assign cnt_sel   = (apb_paddr[19:2] == TMR_CNT0[19:2]);
  assign stat_sel  = (apb_paddr == TMR_STAT);
  assign lane      = apb_paddr[1:0];

  // A byte write to CNT swallows that cycle's tick entirely: no increment, no match
  assign cnt_wr    = we & cnt_sel;
  assign cnt_hit   = (cnt == cmp);
  assign match_set = tick & ~cnt_wr & cnt_hit;

  // Restarting the timer (EN 0->1) realigns the prescaler phase
  assign pre_clr = we & ctrl_sel & ~ctrl.en & apb_pwdata[CTRL_EN];

  tmr_prescaler #(
    .PRE_W (PRE_W)
  ) u_prescaler (
    .apb_pclk (apb_pclk),
    .rst      (rst),
    .en       (ctrl.en),
    .clr      (pre_clr),
    .presc    (presc),
    .tick     (tick)
  );

  // CTRL: a bus write beats the one-shot auto-disable landing in the same cycle
  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      ctrl <= '0;
    end else if (we && ctrl_sel) begin
      ctrl.en       <= apb_pwdata[CTRL_EN];
      ctrl.periodic <= apb_pwdata[CTRL_PERIODIC];
      ctrl.irq_en   <= apb_pwdata[CTRL_IRQ_EN];
`ifdef TIMER_PWM_EN
      ctrl.pwm_en   <= apb_pwdata[CTRL_PWM_EN];
`else
      ctrl.pwm_en   <= 1'b0;
`endif
    end else if (match_set && !ctrl.periodic) begin
      ctrl.en <= 1'b0;
    end
  end

  // PRESC and CMP are plain bus registers; compare sees a new CMP byte from the next cycle
  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      presc <= '0;
      cmp   <= '1;
    end else if (we) begin
      if (presc_sel) presc <= apb_pwdata;
      if (cmp_sel)   cmp[{lane, 3'b000} +: 8] <= apb_pwdata;
    end
  end

  // Counter: byte load has priority, otherwise advance or resolve a match on each tick
  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      cnt <= '0;
    end else if (cnt_wr) begin
      cnt[{lane, 3'b000} +: 8] <= apb_pwdata;
    end else if (tick) begin
      if (cnt_hit) begin
        if (ctrl.periodic) cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  // MATCH flag: W1C, a new match in the same cycle wins over the clear
  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      match <= 1'b0;
    end else if (match_set) begin
      match <= 1'b1;
    end else if (we && stat_sel && apb_pwdata[STAT_MATCH]) begin
      match <= 1'b0;
    end
  end

  // Reading CNT0 freezes the upper three bytes so a byte-wise read is coherent
  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      snap <= '0;
    end else if (re && cnt_sel && (lane == 2'd0)) begin
      snap <= cnt[CNT_W-1:8];
    end
  end

  assign timer_int = match & ctrl.irq_en;

`ifdef TIMER_PWM_EN
  logic pwm_q;

  // PWM high while the running count is below the compare value
  always_ff @(posedge apb_pclk) begin
    if (rst) begin
      pwm_q <= 1'b0;
    end else begin
      pwm_q <= ctrl.en & ctrl.pwm_en & (cnt < cmp);
    end
  end

  assign pwm_o = pwm_q;
`else
  assign pwm_o = 1'b0;
`endif

  // Read mux, combinational from the address; unmapped locations read zero
  always_comb begin
    apb_prdata = '0;
    if (ctrl_sel) begin
      apb_prdata = {4'b0000, ctrl};
    end else if (presc_sel) begin
      apb_prdata = presc;
    end else if (cmp_sel) begin
      apb_prdata = cmp[{lane, 3'b000} +: 8];
    end else if (cnt_sel) begin
      if (lane == 2'd0) apb_prdata = cnt[7:0];
      else              apb_prdata = snap[{lane - 2'd1, 3'b000} +: 8];
    end else if (stat_sel) begin
      apb_prdata[STAT_MATCH] = match;
      apb_prdata[STAT_RUN]   = ctrl.en;
    end
  end

endmodule
